// File: rtl/multicycle_control_unit.sv
// Control FSM for a multicycle MIPS datapath (IF/ID/EXE/MEM/WB).
// The outputs are decoded from the current state and the opcode held in the instruction register.
module multicycle_control_unit (
  input  logic       CLK,
  input  logic       Reset,
  input  logic [5:0] opCode,
  input  logic       zero,
  input  logic       sign,
  output logic [2:0] state,
  output logic       PCWre,
  output logic       IRWre,
  output logic       InsMemRW,
  output logic       RegWre,
  output logic [1:0] RegDst,
  output logic       WrRegDSrc,
  output logic       DBDataSrc,
  output logic       mRD,
  output logic       mWR,
  output logic       ALUSrcA,
  output logic       ALUSrcB,
  output logic       ExtSel,
  output logic [2:0] ALUOp,
  output logic [1:0] PCSrc
);

  localparam logic [2:0] S_IF     = 3'b000;
  localparam logic [2:0] S_ID     = 3'b001;
  localparam logic [2:0] S_EXE_AL = 3'b110;
  localparam logic [2:0] S_EXE_BR = 3'b101;
  localparam logic [2:0] S_EXE_LS = 3'b010;
  localparam logic [2:0] S_MEM    = 3'b011;
  localparam logic [2:0] S_WB_AL  = 3'b111;
  localparam logic [2:0] S_WB_LD  = 3'b100;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_ADDIU = 6'b000010;
  localparam logic [5:0] OP_AND   = 6'b010000;
  localparam logic [5:0] OP_ANDI  = 6'b010001;
  localparam logic [5:0] OP_ORI   = 6'b010010;
  localparam logic [5:0] OP_SLL   = 6'b011000;
  localparam logic [5:0] OP_SLTI  = 6'b011100;
  localparam logic [5:0] OP_SW    = 6'b110000;
  localparam logic [5:0] OP_LW    = 6'b110001;
  localparam logic [5:0] OP_BEQ   = 6'b110100;
  localparam logic [5:0] OP_BNE   = 6'b110101;
  localparam logic [5:0] OP_BLTZ  = 6'b110110;
  localparam logic [5:0] OP_J     = 6'b111000;
  localparam logic [5:0] OP_JR    = 6'b111001;
  localparam logic [5:0] OP_JAL   = 6'b111010;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  logic [2:0] state_reg;
  logic [2:0] state_next;
  logic [2:0] dec_state;

  logic is_rtype, is_imm, is_ls, is_branch, is_halt, is_zext, is_alu;
  logic is_j, is_jr, is_jal, is_lw, is_sw;
  logic branch_taken, alu_state;
  logic [2:0] alu_op_dec;
  logic pc_wre_raw, ir_wre_raw, reg_wre_raw, m_wr_raw;

  always_comb begin
    is_rtype  = (opCode == OP_ADD) || (opCode == OP_SUB) ||
                (opCode == OP_AND) || (opCode == OP_SLL);
    is_imm    = (opCode == OP_ADDIU) || (opCode == OP_ANDI) ||
                (opCode == OP_ORI) || (opCode == OP_SLTI);
    is_lw     = (opCode == OP_LW);
    is_sw     = (opCode == OP_SW);
    is_ls     = is_lw || is_sw;
    is_branch = (opCode == OP_BEQ) || (opCode == OP_BNE) || (opCode == OP_BLTZ);
    is_j      = (opCode == OP_J);
    is_jr     = (opCode == OP_JR);
    is_jal    = (opCode == OP_JAL);
    is_halt   = (opCode == OP_HALT);
    is_zext   = (opCode == OP_ANDI) || (opCode == OP_ORI);
    is_alu    = is_rtype || is_imm;
    branch_taken = ((opCode == OP_BEQ) && zero) ||
                   ((opCode == OP_BNE) && !zero) ||
                   ((opCode == OP_BLTZ) && sign);
  end

  always_comb begin
    case (opCode)
      OP_SUB, OP_BEQ, OP_BNE, OP_BLTZ: alu_op_dec = 3'b001;
      OP_AND, OP_ANDI:                 alu_op_dec = 3'b100;
      OP_ORI:                          alu_op_dec = 3'b011;
      OP_SLL:                          alu_op_dec = 3'b010;
      OP_SLTI:                         alu_op_dec = 3'b110;
      default:                         alu_op_dec = 3'b000;
    endcase
  end

  always_comb begin
    state_next = S_IF;
    case (state_reg)
      S_IF: state_next = S_ID;
      S_ID: begin
        if (is_halt)        state_next = S_ID;
        else if (is_branch) state_next = S_EXE_BR;
        else if (is_ls)     state_next = S_EXE_LS;
        else if (is_alu)    state_next = S_EXE_AL;
        else                state_next = S_IF;
      end
      S_EXE_AL: state_next = S_WB_AL;
      S_EXE_LS: state_next = S_MEM;
      S_MEM:    state_next = is_lw ? S_WB_LD : S_IF;
      default:  state_next = S_IF;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Reset) state_reg <= S_IF;
    else       state_reg <= state_next;
  end

  assign state = state_reg;

  // While in reset the outputs decode as sIF, so an aborted instruction cannot leak strobes.
  assign dec_state = Reset ? S_IF : state_reg;
  assign alu_state = (dec_state == S_EXE_AL) || (dec_state == S_EXE_BR) ||
                     (dec_state == S_EXE_LS) || (dec_state == S_WB_AL) ||
                     (dec_state == S_WB_LD);

  always_comb begin
    pc_wre_raw  = 1'b0;
    ir_wre_raw  = 1'b0;
    reg_wre_raw = 1'b0;
    m_wr_raw    = 1'b0;
    InsMemRW    = 1'b0;
    RegDst      = 2'b00;
    WrRegDSrc   = 1'b0;
    DBDataSrc   = 1'b0;
    mRD         = 1'b0;
    PCSrc       = 2'b00;
    case (dec_state)
      S_IF: begin
        InsMemRW   = 1'b1;
        ir_wre_raw = 1'b1;
      end
      S_ID: begin
        if (is_j || is_jal) PCSrc = 2'b11;
        else if (is_jr)     PCSrc = 2'b10;
        if (is_jal) reg_wre_raw = 1'b1;
        pc_wre_raw = !(is_halt || is_branch || is_ls || is_alu);
      end
      S_EXE_BR: begin
        pc_wre_raw = 1'b1;
        if (branch_taken) PCSrc = 2'b01;
      end
      S_MEM: begin
        m_wr_raw   = is_sw;
        mRD        = is_lw;
        pc_wre_raw = !is_lw;
      end
      S_WB_AL: begin
        pc_wre_raw  = 1'b1;
        reg_wre_raw = 1'b1;
        WrRegDSrc   = 1'b1;
        RegDst      = is_rtype ? 2'b10 : 2'b01;
      end
      S_WB_LD: begin
        pc_wre_raw  = 1'b1;
        reg_wre_raw = 1'b1;
        WrRegDSrc   = 1'b1;
        DBDataSrc   = 1'b1;
        RegDst      = 2'b01;
        mRD         = 1'b1;
      end
      default: ;
    endcase
  end

  assign PCWre   = pc_wre_raw & ~Reset;
  assign IRWre   = ir_wre_raw & ~Reset;
  assign RegWre  = reg_wre_raw & ~Reset;
  assign mWR     = m_wr_raw & ~Reset;
  assign ALUSrcA = alu_state & (opCode == OP_SLL);
  assign ALUSrcB = alu_state & (is_imm | is_ls);
  assign ExtSel  = alu_state & ~is_zext;
  assign ALUOp   = alu_state ? alu_op_dec : 3'b000;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench: directed cycles push hand-computed output vectors, a negedge monitor pops and checks.
module tb_multicycle_control_unit;

  logic       CLK = 1'b0;
  logic       Reset;
  logic [5:0] opCode;
  logic       zero, sign;
  logic [2:0] state;
  logic       PCWre, IRWre, InsMemRW, RegWre;
  logic [1:0] RegDst;
  logic       WrRegDSrc, DBDataSrc, mRD, mWR, ALUSrcA, ALUSrcB, ExtSel;
  logic [2:0] ALUOp;
  logic [1:0] PCSrc;

  typedef struct {
    string       nm;
    logic [20:0] v;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;

  multicycle_control_unit dut (
    .CLK(CLK), .Reset(Reset), .opCode(opCode), .zero(zero), .sign(sign),
    .state(state), .PCWre(PCWre), .IRWre(IRWre), .InsMemRW(InsMemRW),
    .RegWre(RegWre), .RegDst(RegDst), .WrRegDSrc(WrRegDSrc),
    .DBDataSrc(DBDataSrc), .mRD(mRD), .mWR(mWR), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ExtSel(ExtSel), .ALUOp(ALUOp), .PCSrc(PCSrc)
  );

  always #5 CLK = ~CLK;

  // One cycle: drive inputs just after the edge and queue the outputs expected for that cycle.
  task automatic cyc(input logic r, input logic [5:0] o, input logic z, input logic s,
                     input string nm, input logic [2:0] st,
                     input logic pcw, input logic irw, input logic imr, input logic rw,
                     input logic [1:0] rd, input logic wds, input logic dbs,
                     input logic mrd, input logic mwr, input logic asa, input logic asb,
                     input logic ext, input logic [2:0] aop, input logic [1:0] pcs);
    exp_t e;
    @(posedge CLK);
    #1;
    Reset = r; opCode = o; zero = z; sign = s;
    e.nm = nm;
    e.v  = {st, pcw, irw, imr, rw, rd, wds, dbs, mrd, mwr, asa, asb, ext, aop, pcs};
    q.push_back(e);
  endtask

  task automatic fetch(input logic [5:0] o, input string nm);
    cyc(0, o, 0, 0, nm, 3'b000, 0,1,1,0, 2'b00, 0,0,0,0, 0,0,0, 3'b000, 2'b00);
  endtask

  task automatic idle_id(input logic [5:0] o, input string nm);
    cyc(0, o, 0, 0, nm, 3'b001, 0,0,0,0, 2'b00, 0,0,0,0, 0,0,0, 3'b000, 2'b00);
  endtask

  always @(negedge CLK) begin
    logic [20:0] act;
    exp_t e;
    if (q.size() > 0) begin
      e   = q.pop_front();
      act = {state, PCWre, IRWre, InsMemRW, RegWre, RegDst, WrRegDSrc, DBDataSrc,
             mRD, mWR, ALUSrcA, ALUSrcB, ExtSel, ALUOp, PCSrc};
      total++;
      if (act !== e.v) begin
        bad++;
        $display("FAIL %s got=%b want=%b", e.nm, act, e.v);
      end else begin
        $display("chk %s state=%b ok", e.nm, state);
      end
    end
  end

  initial begin
    Reset = 1'b1; opCode = 6'b000000; zero = 1'b0; sign = 1'b0;
    @(posedge CLK);
    cyc(1, 6'b000000, 0, 0, "reset", 3'b000, 0,0,1,0, 2'b00, 0,0,0,0, 0,0,0, 3'b000, 2'b00);

    // add
    fetch(6'b000000, "add_if");
    idle_id(6'b000000, "add_id");
    cyc(0, 6'b000000, 0, 0, "add_exe", 3'b110, 0,0,0,0, 2'b00, 0,0,0,0, 0,0,1, 3'b000, 2'b00);
    cyc(0, 6'b000000, 0, 0, "add_wb",  3'b111, 1,0,0,1, 2'b10, 1,0,0,0, 0,0,1, 3'b000, 2'b00);

    // lw
    fetch(6'b110001, "lw_if");
    idle_id(6'b110001, "lw_id");
    cyc(0, 6'b110001, 0, 0, "lw_exe", 3'b010, 0,0,0,0, 2'b00, 0,0,0,0, 0,1,1, 3'b000, 2'b00);
    cyc(0, 6'b110001, 0, 0, "lw_mem", 3'b011, 0,0,0,0, 2'b00, 0,0,1,0, 0,0,0, 3'b000, 2'b00);
    cyc(0, 6'b110001, 0, 0, "lw_wb",  3'b100, 1,0,0,1, 2'b01, 1,1,1,0, 0,1,1, 3'b000, 2'b00);

    // sw
    fetch(6'b110000, "sw_if");
    idle_id(6'b110000, "sw_id");
    cyc(0, 6'b110000, 0, 0, "sw_exe", 3'b010, 0,0,0,0, 2'b00, 0,0,0,0, 0,1,1, 3'b000, 2'b00);
    cyc(0, 6'b110000, 0, 0, "sw_mem", 3'b011, 1,0,0,0, 2'b00, 0,0,0,1, 0,0,0, 3'b000, 2'b00);

    // beq taken / not taken, bne taken, bltz taken
    fetch(6'b110100, "beq1_if");
    idle_id(6'b110100, "beq1_id");
    cyc(0, 6'b110100, 1, 0, "beq1_br", 3'b101, 1,0,0,0, 2'b00, 0,0,0,0, 0,0,1, 3'b001, 2'b01);
    fetch(6'b110100, "beq0_if");
    idle_id(6'b110100, "beq0_id");
    cyc(0, 6'b110100, 0, 0, "beq0_br", 3'b101, 1,0,0,0, 2'b00, 0,0,0,0, 0,0,1, 3'b001, 2'b00);
    fetch(6'b110101, "bne_if");
    idle_id(6'b110101, "bne_id");
    cyc(0, 6'b110101, 0, 0, "bne_br", 3'b101, 1,0,0,0, 2'b00, 0,0,0,0, 0,0,1, 3'b001, 2'b01);
    fetch(6'b110110, "bltz_if");
    idle_id(6'b110110, "bltz_id");
    cyc(0, 6'b110110, 0, 1, "bltz_br", 3'b101, 1,0,0,0, 2'b00, 0,0,0,0, 0,0,1, 3'b001, 2'b01);

    // jumps
    fetch(6'b111010, "jal_if");
    cyc(0, 6'b111010, 0, 0, "jal_id", 3'b001, 1,0,0,1, 2'b00, 0,0,0,0, 0,0,0, 3'b000, 2'b11);
    fetch(6'b111001, "jr_if");
    cyc(0, 6'b111001, 0, 0, "jr_id",  3'b001, 1,0,0,0, 2'b00, 0,0,0,0, 0,0,0, 3'b000, 2'b10);
    fetch(6'b111000, "j_if");
    cyc(0, 6'b111000, 0, 0, "j_id",   3'b001, 1,0,0,0, 2'b00, 0,0,0,0, 0,0,0, 3'b000, 2'b11);

    // ori (zero-extend), sll (shift amount on A)
    fetch(6'b010010, "ori_if");
    idle_id(6'b010010, "ori_id");
    cyc(0, 6'b010010, 0, 0, "ori_exe", 3'b110, 0,0,0,0, 2'b00, 0,0,0,0, 0,1,0, 3'b011, 2'b00);
    cyc(0, 6'b010010, 0, 0, "ori_wb",  3'b111, 1,0,0,1, 2'b01, 1,0,0,0, 0,1,0, 3'b011, 2'b00);
    fetch(6'b011000, "sll_if");
    idle_id(6'b011000, "sll_id");
    cyc(0, 6'b011000, 0, 0, "sll_exe", 3'b110, 0,0,0,0, 2'b00, 0,0,0,0, 1,0,1, 3'b010, 2'b00);
    cyc(0, 6'b011000, 0, 0, "sll_wb",  3'b111, 1,0,0,1, 2'b10, 1,0,0,0, 1,0,1, 3'b010, 2'b00);

    // undefined opcode retires from sID
    fetch(6'b000011, "undef_if");
    cyc(0, 6'b000011, 0, 0, "undef_id", 3'b001, 1,0,0,0, 2'b00, 0,0,0,0, 0,0,0, 3'b000, 2'b00);

    // halt stalls in sID until reset
    fetch(6'b111111, "halt_if");
    for (int i = 0; i < 20; i++) idle_id(6'b111111, "halt_id");
    cyc(1, 6'b111111, 0, 0, "halt_rst", 3'b001, 0,0,1,0, 2'b00, 0,0,0,0, 0,0,0, 3'b000, 2'b00);
    fetch(6'b110000, "post_halt_if");

    // reset during sMEM of sw aborts the store
    idle_id(6'b110000, "swr_id");
    cyc(0, 6'b110000, 0, 0, "swr_exe", 3'b010, 0,0,0,0, 2'b00, 0,0,0,0, 0,1,1, 3'b000, 2'b00);
    cyc(1, 6'b110000, 0, 0, "swr_mem_rst", 3'b011, 0,0,1,0, 2'b00, 0,0,0,0, 0,0,0, 3'b000, 2'b00);
    fetch(6'b110000, "swr_after_if");

    repeat (3) @(posedge CLK);
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Moore-style FSM that sequences the multicycle MIPS datapath through IF/ID/EXE/MEM/WB.
- Generates the instruction register's IRWre, the PC write enable, register-file and data-memory strobes, and mux selects.
- Decodes opCode as held by the instruction register, so opCode is valid from sID onward.
- Sits between the instruction register and the PC, ALU, register file and data memory.

Parameters:
- None. Opcode and state encodings below are fixed.

Ports:
- CLK  in  1  system clock, rising edge
- Reset  in  1  synchronous, active-high reset
- opCode  in  6  opcode field from the instruction register
- zero  in  1  ALU result == 0
- sign  in  1  ALU result bit 31
- state  out  3  current state, for debug
- PCWre  out  1  PC write enable
- IRWre  out  1  instruction register load enable
- InsMemRW  out  1  instruction memory read, 1 = read
- RegWre  out  1  register-file write enable
- RegDst  out  2  write-register select: 00 = $31, 01 = rt, 10 = rd
- WrRegDSrc  out  1  write-data select: 0 = PC+4, 1 = DB bus
- DBDataSrc  out  1  DB bus source: 0 = ALU, 1 = data memory
- mRD  out  1  data-memory read
- mWR  out  1  data-memory write
- ALUSrcA  out  1  ALU A input: 0 = rs, 1 = sa
- ALUSrcB  out  1  ALU B input: 0 = rt, 1 = extended immediate
- ExtSel  out  1  immediate extension: 0 = zero-extend, 1 = sign-extend
- ALUOp  out  3  000 add, 001 sub, 010 sll (B<<A), 011 or, 100 and, 110 slt (signed)
- PCSrc  out  2  next-PC select: 00 = PC+4, 01 = PC+4+(sext(imm)<<2), 10 = rs, 11 = {PC[31:28], j_addr, 2'b00}

Behaviour:
- Clock and reset: one clock (CLK); Reset is synchronous and active-high.
- Reset: at any rising edge with Reset=1, state <= sIF. This includes reset mid-instruction, which aborts the instruction.
- While Reset=1, PCWre, IRWre, RegWre and mWR are forced to 0. All other outputs follow the sIF decode.

State encoding:
- sIF=000, sID=001, sEXE_AL=110, sEXE_BR=101, sEXE_LS=010, sMEM=011, sWB_AL=111, sWB_LD=100.

Opcode set:
- add 000000, sub 000001, addiu 000010
- and 010000, andi 010001, ori 010010
- sll 011000, slti 011100
- sw 110000, lw 110001
- beq 110100, bne 110101, bltz 110110
- j 111000, jr 111001, jal 111010
- halt 111111

Transitions:
- sIF -> sID, always.
- sID -> sIF for j, jr, jal, and for any undefined opcode.
- sID -> sID for halt (stall until Reset).
- sID -> sEXE_BR for beq, bne, bltz.
- sID -> sEXE_LS for lw, sw.
- sID -> sEXE_AL for all remaining ALU ops.
- sEXE_AL -> sWB_AL -> sIF.
- sEXE_BR -> sIF.
- sEXE_LS -> sMEM.
- sMEM -> sIF for sw; sMEM -> sWB_LD for lw.
- sWB_LD -> sIF.

Per-state outputs (anything not listed is 0):
- sIF: InsMemRW=1, IRWre=1. The instruction register loads at the edge leaving sIF.
- PCWre=1 for exactly one cycle per instruction, in its final state: sID (j/jr/jal/undefined), sWB_AL, sEXE_BR, sMEM (sw), sWB_LD. PCWre is never 1 in sIF, and never 1 during halt.
- PCSrc:
  - j/jal: 11
  - jr: 10
  - branch taken: 01. Taken means beq & zero, bne & ~zero, or bltz & sign.
  - all other cases: 00
- jal in sID: RegWre=1, RegDst=00, WrRegDSrc=0.
- EXE and WB states of an instruction hold identical ALUSrcA/ALUSrcB/ALUOp/ExtSel values:
  - sll: ALUSrcA=1.
  - addiu, andi, ori, slti, lw, sw: ALUSrcB=1.
  - ExtSel=0 for andi and ori; ExtSel=1 otherwise.
  - Branches: ALUOp=001. bltz compares rs against rt=$0.
- sMEM: mWR=1 for sw; mRD=1 for lw.
- sWB_AL: RegWre=1, WrRegDSrc=1, DBDataSrc=0. RegDst=10 for R-type (add/sub/and/sll), 01 for immediate ops.
- sWB_LD: RegWre=1, WrRegDSrc=1, DBDataSrc=1, RegDst=01, mRD=1.

Latency (cycles per instruction):
- j / jr / jal: 2
- branch: 3
- ALU and sw: 4
- lw: 5

Test Plan:
- Reset=1 for 2 cycles, then add (000000) -> state 000,001,110,111,000. IRWre=1 only in the first cycle. PCWre=1 only in sWB_AL with RegDst=10, RegWre=1.
- lw (110001) -> 5 cycles ending in sWB_LD with DBDataSrc=1, RegDst=01, RegWre=1. sw (110000) -> mWR=1 in sMEM, PCWre=1 there, never RegWre.
- beq with zero=1 -> sEXE_BR shows PCSrc=01, PCWre=1. Repeat with zero=0 -> PCSrc=00. bltz with sign=1 -> PCSrc=01.
- jal (111010) -> sID shows RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1, then sIF. jr -> PCSrc=10.
- halt (111111) -> state stays 001 for 20 cycles with PCWre=IRWre=0. Then Reset=1 -> state 000 next edge.
- Reset asserted in sMEM of an sw -> mWR=0 immediately, state=000 after the edge, no register write occurs.
